trdb_word_buffer: RTL
=====================

TRDB_WORD_BUFFER -- requirements
Module: trdb_word_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, word capacity; power of two, >= 4.
REQ-002 SHALL have parameter DROP_CNT_W, default 16, width of the total drop counter.
REQ-003 SHALL have parameter MARKER_TAG, default 16'hFFFF, upper half of the overflow marker word.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port clear_i, input, 1, synchronous flush of contents and statistics.
REQ-007 SHALL have port data_i, input, 32, aligned trace word from the upstream packet-to-word aligner.
REQ-008 SHALL have port valid_i, input, 1, data_i valid; upstream has no backpressure.
REQ-009 SHALL have port data_o, output, 32, head word.
REQ-010 SHALL have port valid_o, output, 1, head word valid (buffer non-empty).
REQ-011 SHALL have port ready_i, input, 1, sink accepts head word.
REQ-012 SHALL have port fill_o, output, $clog2(DEPTH)+1, stored word count.
REQ-013 SHALL have port overflow_o, output, 1, sticky: at least one word dropped since reset/clear.
REQ-014 SHALL have port drop_cnt_o, output, DROP_CNT_W, total dropped words, saturating.

Function
REQ-015 SHALL implement a circular buffer with read/write pointers wrapping modulo DEPTH and a fill counter.
REQ-016 SHALL be first-word-fall-through: valid_o = (fill != 0); data_o = mem[rd_ptr].
REQ-017 SHALL pop when valid_o && ready_i; pop advances rd_ptr by 1.
REQ-018 SHALL make a word written in cycle N visible on data_o/valid_o in cycle N+1 at the earliest.
REQ-019 SHALL have FSM states NORMAL and DROPPING; reset state NORMAL.
REQ-020 In NORMAL: SHALL write data_i when valid_i && (fill < DEPTH || pop).
- Push on full with concurrent pop is accepted; fill is unchanged.
REQ-021 In NORMAL: valid_i && fill == DEPTH && !pop SHALL:
- drop the word, increment drop_cnt and burst_cnt, set overflow_o;
- go to DROPPING.
REQ-022 In DROPPING: SHALL drop every valid_i word (increment drop_cnt, burst_cnt) while fill == DEPTH && !pop.
REQ-023 In DROPPING, when fill < DEPTH || pop, SHALL write one marker word and return to NORMAL:
- marker = {MARKER_TAG, sat16(burst_cnt + valid_i)};
- a valid_i word in that same cycle SHALL be dropped and counted in drop_cnt.
REQ-024 burst_cnt SHALL be a 16-bit internal counter, saturating at 16'hFFFF, cleared on marker write.
REQ-025 drop_cnt_o SHALL saturate at all-ones.
REQ-026 SHALL never write more than one word per cycle; fill_o SHALL never exceed DEPTH.
REQ-027 clear_i SHALL take priority over push, pop and FSM transitions. Next cycle:
- fill 0, pointers 0, valid_o 0;
- overflow_o 0, drop_cnt_o 0, burst_cnt 0, state NORMAL.
REQ-028 The word presented on data_i or data_o during a clear_i cycle SHALL be discarded, not counted as dropped.

Reset
REQ-029 rst_i high at a clock edge SHALL return all of the following to 0, regardless of state or in-flight traffic:
- fill_o, valid_o, overflow_o, drop_cnt_o, burst_cnt, pointers;
- data_o; state SHALL return to NORMAL.
REQ-030 Memory contents need not be reset; data_o SHALL read 0 while empty.

Verification
REQ-031 DEPTH=4, ready_i=0, push 0xA,0xB,0xC in consecutive cycles -> valid_o=1 and data_o=0xA from the cycle after the first push, fill_o=3; then ready_i=1 -> 0xA,0xB,0xC popped in order, then valid_o=0.
REQ-032 DEPTH=4, ready_i=0, push 0x1..0x6 -> 0x5,0x6 dropped, overflow_o=1, drop_cnt_o=2; then valid_i=0 and one pop -> next cycle marker 0xFFFF0002 stored; subsequent pops yield 0x2,0x3,0x4,0xFFFF0002.
REQ-033 DEPTH=4 full, valid_i=1 and ready_i=1 for 3 cycles -> no drops, fill_o stays 4, FIFO order preserved across pointer wrap.
REQ-034 DROPPING with valid_i=1 on the exit cycle after 3 drops -> marker 0xFFFF0004 written, drop_cnt_o=4, state NORMAL.
REQ-035 DROP_CNT_W=4, 20 drops -> drop_cnt_o=15; then clear_i with valid_i=1, ready_i=1 -> next cycle fill_o=0, overflow_o=0, drop_cnt_o=0.
REQ-036 rst_i asserted while in DROPPING with fill_o=4 -> next cycle all outputs 0, state NORMAL; first push afterwards behaves as in REQ-031.

Source files
------------

// File: rtl/trdb_word_buffer.sv
// Trace word buffer: FWFT circular FIFO that drops words on overflow and
// records each drop burst with a single marker word once space returns.
//
// state        | meaning
// -------------|-------------------------------------------------------
// ST_NORMAL    | words written while there is room (or a pop this cycle)
// ST_DROPPING  | buffer stayed full; incoming words dropped and counted
module trdb_word_buffer #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DROP_CNT_W = 16,
    parameter logic [15:0] MARKER_TAG = 16'hFFFF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic [31:0]             data_i,
    input  logic                    valid_i,
    output logic [31:0]             data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [$clog2(DEPTH):0]  fill_o,
    output logic                    overflow_o,
    output logic [DROP_CNT_W-1:0]   drop_cnt_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);

    typedef enum logic {
        ST_NORMAL   = 1'b0,
        ST_DROPPING = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [31:0]             mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0]       fill_q;
    logic                    ovf_q;
    logic [DROP_CNT_W-1:0]   drop_cnt_q;
    logic [15:0]             burst_q;

    logic                    pop;
    logic                    space;
    logic                    wr_en;
    logic [31:0]             wr_data;
    logic                    drop;
    logic                    burst_clr;
    logic [15:0]             marker_cnt;

    assign pop        = (fill_q != '0) && ready_i;
    assign space      = (fill_q != FULL_LVL) || pop;
    assign marker_cnt = (burst_q == 16'hFFFF) ? 16'hFFFF : burst_q + {15'd0, valid_i};

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= ST_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        wr_data   = data_i;
        drop      = 1'b0;
        burst_clr = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                if (valid_i) begin
                    if (space) begin
                        wr_en = 1'b1;
                    end else begin
                        drop    = 1'b1;
                        state_d = ST_DROPPING;
                    end
                end
            end
            ST_DROPPING: begin
                // The marker takes the free slot, so a word arriving now is lost too.
                drop = valid_i;
                if (space) begin
                    wr_en     = 1'b1;
                    wr_data   = {MARKER_TAG, marker_cnt};
                    burst_clr = 1'b1;
                    state_d   = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            burst_q    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   fill_q <= fill_q + FILL_W'(1);
                2'b01:   fill_q <= fill_q - FILL_W'(1);
                default: fill_q <= fill_q;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
                end
            end
            if (burst_clr) begin
                burst_q <= '0;
            end else if (drop && (burst_q != 16'hFFFF)) begin
                burst_q <= burst_q + 16'd1;
            end
        end
    end

    // Storage is deliberately left unreset; data_o is masked while empty.
    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i && !clear_i) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign valid_o    = (fill_q != '0);
    assign data_o     = valid_o ? mem[rd_ptr_q] : 32'd0;
    assign fill_o     = fill_q;
    assign overflow_o = ovf_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule
